// File: rtl/nf_ahb_tmr.sv
// AHB-Lite slave timer: prescaled up-counter with compare match, optional
// auto-clear and a level interrupt. Zero wait states, always OKAY.
module nf_ahb_tmr #(
  parameter int tmr_w = 32
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr_s,
  input  logic [31:0] hwdata_s,
  output logic [31:0] hrdata_s,
  input  logic        hwrite_s,
  input  logic [1:0]  htrans_s,
  input  logic [2:0]  hsize_s,
  input  logic [2:0]  hburst_s,
  output logic [1:0]  hresp_s,
  output logic        hready_s,
  input  logic        hsel_s,
  output logic        tmr_irq
);

  localparam logic [2:0]  off_cnt    = 3'd0;
  localparam logic [2:0]  off_cmp    = 3'd1;
  localparam logic [2:0]  off_ctrl   = 3'd2;
  localparam logic [2:0]  off_status = 3'd3;
  localparam logic [15:0] ctrl_mask  = 16'hFF07;

  logic             wr_pend;
  logic [2:0]       wr_off;
  logic [tmr_w-1:0] cnt, cmp;
  logic [15:0]      ctrl;
  logic [7:0]       psc_cnt;
  logic             match;

  logic             acc, tick, match_set;
  logic             wr_cnt, wr_cmp, wr_ctrl, wr_status;
  logic [tmr_w-1:0] cnt_nxt, cmp_nxt;
  logic [15:0]      ctrl_nxt;
  logic [7:0]       psc_nxt;
  logic             match_nxt;
  logic [2:0]       rd_off;
  logic [31:0]      rd_val;

  logic unused_bits;
  assign unused_bits = ^{hsize_s, hburst_s, haddr_s[31:5], haddr_s[1:0], htrans_s[0]};

  assign hready_s = 1'b1;
  assign hresp_s  = 2'b00;

  assign acc = hsel_s & htrans_s[1];

  assign wr_cnt    = wr_pend && (wr_off == off_cnt);
  assign wr_cmp    = wr_pend && (wr_off == off_cmp);
  assign wr_ctrl   = wr_pend && (wr_off == off_ctrl);
  assign wr_status = wr_pend && (wr_off == off_status);

  assign tick      = ctrl[0] && (psc_cnt == ctrl[15:8]);
  assign match_set = tick && (cnt == cmp);

  function automatic logic [31:0] reg_word(input logic [2:0]       off,
                                           input logic [tmr_w-1:0] c,
                                           input logic [tmr_w-1:0] m,
                                           input logic [15:0]      k,
                                           input logic             s);
    logic [31:0] w;
    w = '0;
    case (off)
      off_cnt:    w = 32'(c);
      off_cmp:    w = 32'(m);
      off_ctrl:   w = {16'h0000, k};
      off_status: w = {31'd0, s};
      default:    w = '0;
    endcase
    return w;
  endfunction

  // Next-state values; a bus write to CNT wins over a tick on the same edge.
  always_comb begin
    cnt_nxt = cnt;
    if (wr_cnt)
      cnt_nxt = hwdata_s[tmr_w-1:0];
    else if (tick)
      cnt_nxt = (match_set && ctrl[1]) ? '0 : cnt + tmr_w'(1);

    psc_nxt = psc_cnt;
    if (wr_cnt || wr_ctrl)
      psc_nxt = '0;
    else if (ctrl[0])
      psc_nxt = tick ? 8'd0 : psc_cnt + 8'd1;

    cmp_nxt   = wr_cmp ? hwdata_s[tmr_w-1:0] : cmp;
    ctrl_nxt  = wr_ctrl ? (hwdata_s[15:0] & ctrl_mask) : ctrl;
    match_nxt = match_set | (match & ~(wr_status & hwdata_s[0]));
  end

  // A read colliding with a pending write to the same offset sees the committed value.
  always_comb begin
    rd_off = haddr_s[4:2];
    if (wr_pend && (wr_off == rd_off))
      rd_val = reg_word(rd_off, cnt_nxt, cmp_nxt, ctrl_nxt, match_nxt);
    else
      rd_val = reg_word(rd_off, cnt, cmp, ctrl, match);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_pend  <= 1'b0;
      wr_off   <= '0;
      cnt      <= '0;
      cmp      <= '0;
      ctrl     <= '0;
      psc_cnt  <= '0;
      match    <= 1'b0;
      hrdata_s <= '0;
    end else begin
      wr_pend <= acc && hwrite_s;
      if (acc)
        wr_off <= haddr_s[4:2];
      if (acc && !hwrite_s)
        hrdata_s <= rd_val;
      cnt     <= cnt_nxt;
      cmp     <= cmp_nxt;
      ctrl    <= ctrl_nxt;
      psc_cnt <= psc_nxt;
      match   <= match_nxt;
    end
  end

  assign tmr_irq = match & ctrl[2];

endmodule

// File: tb/tb_nf_ahb_tmr.sv
// Directed self-checking bench for nf_ahb_tmr: counting, prescaler, wrap,
// bus forwarding, write-1-to-clear and asynchronous reset behaviour.
module tb_nf_ahb_tmr;

  localparam logic [1:0] idle_t   = 2'b00;
  localparam logic [1:0] busy_t   = 2'b01;
  localparam logic [1:0] nonseq_t = 2'b10;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr_s, hwdata_s, hrdata_s;
  logic        hwrite_s, hsel_s, hready_s, tmr_irq;
  logic [1:0]  htrans_s, hresp_s;
  logic [2:0]  hsize_s, hburst_s;

  int test_count = 0;
  int fail_count = 0;

  nf_ahb_tmr #(.tmr_w(32)) dut (
    .hclk(hclk), .hreset(hreset), .haddr_s(haddr_s), .hwdata_s(hwdata_s),
    .hrdata_s(hrdata_s), .hwrite_s(hwrite_s), .htrans_s(htrans_s),
    .hsize_s(hsize_s), .hburst_s(hburst_s), .hresp_s(hresp_s),
    .hready_s(hready_s), .hsel_s(hsel_s), .tmr_irq(tmr_irq)
  );

  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One bus cycle: drive inputs just after an edge, then step past the next edge.
  task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic wr,
                               input logic [1:0] trans, input logic [31:0] wdata);
    hsel_s   = sel;
    haddr_s  = addr;
    hwrite_s = wr;
    htrans_s = trans;
    hwdata_s = wdata;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, idle_t, 32'h0);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b1, nonseq_t, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, idle_t, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0, nonseq_t, 32'h0);
    data = hrdata_s;
  endtask

  task automatic do_reset();
    hreset   = 1'b1;
    hsel_s   = 1'b0;
    haddr_s  = '0;
    hwrite_s = 1'b0;
    htrans_s = idle_t;
    hwdata_s = '0;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] seq32 [7];
    logic [31:0] seq34 [4];
    logic        irq34 [4];

    hsize_s  = 3'b010;
    hburst_s = 3'b000;
    do_reset();

    checkOutput("rst_hrdata", hrdata_s, 32'h0);
    checkOutput("rst_irq", {31'd0, tmr_irq}, 32'h0);
    checkOutput("hready", {31'd0, hready_s}, 32'h1);
    checkOutput("hresp", {30'd0, hresp_s}, 32'h0);

    // Compare 5 with auto-clear: 0..5 then back to 0, match raised on the 5 tick
    seq32 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    bus_write(32'h4, 32'd5);
    bus_write(32'h8, 32'h0000_0007);
    for (int i = 0; i < 7; i++) begin
      bus_read(32'h0, rd);
      checkOutput($sformatf("autoclr_cnt%0d", i), rd, seq32[i]);
      if (i == 4) checkOutput("autoclr_irq_before", {31'd0, tmr_irq}, 32'h0);
      if (i == 5) checkOutput("autoclr_irq_after", {31'd0, tmr_irq}, 32'h1);
    end

    // Prescaler 3: one increment every four cycles
    do_reset();
    bus_write(32'h8, 32'h0000_0301);
    for (int i = 0; i < 9; i++) begin
      bus_read(32'h0, rd);
      checkOutput($sformatf("psc3_cnt%0d", i), rd, 32'(i / 4));
    end

    do_reset();
    bus_write(32'h8, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h0, rd);
      checkOutput($sformatf("psc0_cnt%0d", i), rd, 32'(i));
    end

    // Wrap through all-ones; match only when the counter passes CMP=0
    do_reset();
    seq34 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    irq34 = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus_write(32'h0, 32'hFFFF_FFFE);
    bus_write(32'h4, 32'h0);
    bus_write(32'h8, 32'h0000_0005);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h0, rd);
      checkOutput($sformatf("wrap_cnt%0d", i), rd, seq34[i]);
      checkOutput($sformatf("wrap_irq%0d", i), {31'd0, tmr_irq}, {31'd0, irq34[i]});
    end

    // Back-to-back write/read forwarding, hold behaviour, unmapped offset
    do_reset();
    applyStimulus(1'b1, 32'h4, 1'b1, nonseq_t, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, nonseq_t, 32'h0000_1234);
    checkOutput("fwd_cmp", hrdata_s, 32'h0000_1234);
    idle_cycles(1);
    checkOutput("hold_idle", hrdata_s, 32'h0000_1234);
    applyStimulus(1'b0, 32'h14, 1'b0, nonseq_t, 32'h0);
    checkOutput("hold_nosel", hrdata_s, 32'h0000_1234);
    applyStimulus(1'b1, 32'h14, 1'b0, nonseq_t, 32'h0);
    checkOutput("read_0x14", hrdata_s, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, busy_t, 32'h0);
    checkOutput("hold_busy", hrdata_s, 32'h0);
    bus_read(32'h4, rd);
    checkOutput("read_cmp", rd, 32'h0000_1234);
    bus_write(32'h8, 32'hFFFF_FFF0);
    bus_read(32'h8, rd);
    checkOutput("ctrl_mask", rd, 32'h0000_FF00);

    // STATUS clear colliding with a match: set wins; later clear succeeds
    do_reset();
    bus_write(32'h4, 32'd3);
    bus_write(32'h8, 32'h0000_0007);
    idle_cycles(2);
    applyStimulus(1'b1, 32'hC, 1'b1, nonseq_t, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, idle_t, 32'h1);
    checkOutput("setwins_irq", {31'd0, tmr_irq}, 32'h1);
    bus_write(32'h8, 32'h0000_0004);
    bus_read(32'hC, rd);
    checkOutput("setwins_status", rd, 32'h1);
    applyStimulus(1'b1, 32'hC, 1'b1, nonseq_t, 32'h0);
    applyStimulus(1'b1, 32'hC, 1'b0, nonseq_t, 32'h1);
    checkOutput("clr_fwd_status", hrdata_s, 32'h0);
    checkOutput("clr_irq", {31'd0, tmr_irq}, 32'h0);
    idle_cycles(1);
    bus_read(32'hC, rd);
    checkOutput("clr_status", rd, 32'h0);

    // Reset mid-count, overlapping the data phase of a CNT write
    do_reset();
    bus_write(32'h4, 32'd2);
    bus_write(32'h8, 32'h0000_0005);
    idle_cycles(4);
    checkOutput("pre_rst_irq", {31'd0, tmr_irq}, 32'h1);
    bus_read(32'h0, rd);
    checkOutput("pre_rst_cnt", rd, 32'd4);
    applyStimulus(1'b1, 32'h0, 1'b1, nonseq_t, 32'h0);
    hsel_s   = 1'b0;
    htrans_s = idle_t;
    hwdata_s = 32'h0000_ABCD;
    hreset   = 1'b1;
    #1;
    checkOutput("async_rst_hrdata", hrdata_s, 32'h0);
    checkOutput("async_rst_irq", {31'd0, tmr_irq}, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    bus_read(32'h0, rd);
    checkOutput("post_rst_cnt", rd, 32'h0);
    bus_read(32'h4, rd);
    checkOutput("post_rst_cmp", rd, 32'h0);
    bus_read(32'h8, rd);
    checkOutput("post_rst_ctrl", rd, 32'h0);
    bus_read(32'hC, rd);
    checkOutput("post_rst_status", rd, 32'h0);
    idle_cycles(3);
    bus_read(32'h0, rd);
    checkOutput("post_rst_cnt_hold", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
